// File: rtl/delay_pulse_out.sv
// Tick-counted delay/width pulse generator: out rises 1 clk after the delay's last tick, falls 1 clk after the width's last tick; no backpressure.
// Optional RETRIG_EN: a trigger edge during DELAY restarts the delay instead of flagging overrun.
module delay_pulse_out #(
    parameter int DELAY_W = 24,
    parameter int WIDTH_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    input  logic               trig,
    input  logic [DELAY_W-1:0] delay,
    input  logic [WIDTH_W-1:0] width,
    input  logic               ovr_clr,
    output logic               out,
    output logic               busy,
    output logic               done,
    output logic               overrun
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        PULSE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               trig_q;
    logic [DELAY_W-1:0] dcnt_q, dcnt_d;
    logic [WIDTH_W-1:0] wcnt_q, wcnt_d;
    logic               out_q, out_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               ovr_q, ovr_d;

    logic               trig_edge;
    logic               accept;
    logic               ovr_set;
    logic [WIDTH_W-1:0] width_lat;

    assign trig_edge = trig & ~trig_q;
    assign width_lat = (width == '0) ? WIDTH_W'(1) : width;

`ifdef RETRIG_EN
    assign accept = trig_edge && (state_q == IDLE || state_q == DELAY);
`else
    assign accept = trig_edge && (state_q == IDLE);
`endif
    assign ovr_set = trig_edge && !accept;

    always_comb begin
        state_d = state_q;
        dcnt_d  = dcnt_q;
        wcnt_d  = wcnt_q;
        out_d   = out_q;
        done_d  = 1'b0;
        if (accept) begin
            // Ticks in the capture cycle are deliberately not counted.
            dcnt_d = delay;
            wcnt_d = width_lat;
            if (delay == '0) begin
                state_d = PULSE;
                out_d   = 1'b1;
            end else begin
                state_d = DELAY;
                out_d   = 1'b0;
            end
        end else begin
            case (state_q)
                DELAY: begin
                    if (tick && dcnt_q != '0) begin
                        dcnt_d = dcnt_q - DELAY_W'(1);
                        if (dcnt_q == DELAY_W'(1)) begin
                            state_d = PULSE;
                            out_d   = 1'b1;
                        end
                    end
                end
                PULSE: begin
                    if (tick && wcnt_q != '0) begin
                        wcnt_d = wcnt_q - WIDTH_W'(1);
                        if (wcnt_q == WIDTH_W'(1)) begin
                            state_d = IDLE;
                            out_d   = 1'b0;
                            done_d  = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    out_d   = 1'b0;
                end
            endcase
        end
        busy_d = (state_d != IDLE);
        ovr_d  = ovr_set ? 1'b1 : (ovr_clr ? 1'b0 : ovr_q);
    end

    // trig_q resets high so a trigger held through reset is not seen as an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            trig_q  <= 1'b1;
            dcnt_q  <= '0;
            wcnt_q  <= '0;
            out_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            trig_q  <= trig;
            dcnt_q  <= dcnt_d;
            wcnt_q  <= wcnt_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ovr_q   <= ovr_d;
        end
    end

    assign out     = out_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign overrun = ovr_q;

endmodule

// File: tb/tb_delay_pulse_out.sv
// Directed bench for delay_pulse_out (DELAY_W=4); expected waveforms hand-derived per cycle.
module tb_delay_pulse_out;

    logic       clk;
    logic       rst;
    logic       tick;
    logic       trig;
    logic [3:0] delay;
    logic [7:0] width;
    logic       ovr_clr;
    logic       out;
    logic       busy;
    logic       done;
    logic       overrun;

    int errors = 0;
    int checks = 0;

    delay_pulse_out #(
        .DELAY_W(4),
        .WIDTH_W(8)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .tick   (tick),
        .trig   (trig),
        .delay  (delay),
        .width  (width),
        .ovr_clr(ovr_clr),
        .out    (out),
        .busy   (busy),
        .done   (done),
        .overrun(overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clean_start();
        rst     = 1'b1;
        trig    = 1'b0;
        tick    = 1'b0;
        ovr_clr = 1'b0;
        next_cycle();
        rst = 1'b0;
        next_cycle();
        next_cycle();
    endtask

    task automatic test_reset();
        logic [3:0] exp_v;
        exp_v = 4'b0000;
        #2;
        checks++;
        if ({out, busy, done, overrun} !== exp_v) begin
            errors++;
            $display("FAIL reset_async got out/busy/done/ovr=%b want %b", {out, busy, done, overrun}, exp_v);
        end
        trig = 1'b1;
        next_cycle();
        @(negedge clk);
        checks++;
        if ({out, busy, done, overrun} !== exp_v) begin
            errors++;
            $display("FAIL reset_held got out/busy/done/ovr=%b want %b", {out, busy, done, overrun}, exp_v);
        end
    endtask

    task automatic test_basic();
        logic [2:0] exp_v;
        clean_start();
        delay = 4'd3;
        width = 8'd2;
        for (int c = 0; c <= 22; c++) begin
            trig = (c < 3);
            tick = (c inside {2, 6, 10, 14, 18});
            @(negedge clk);
            exp_v = {(c >= 11 && c <= 18), (c >= 1 && c <= 18), (c == 19)};
            checks++;
            if ({out, busy, done} !== exp_v) begin
                errors++;
                $display("FAIL basic c=%0d got out/busy/done=%b want %b", c, {out, busy, done}, exp_v);
            end
            next_cycle();
        end
    endtask

    task automatic test_zero();
        logic [2:0] exp_v;
        clean_start();
        delay = 4'd0;
        width = 8'd0;
        for (int c = 0; c <= 5; c++) begin
            trig = (c < 2);
            tick = (c == 2);
            @(negedge clk);
            exp_v = {(c >= 1 && c <= 2), (c >= 1 && c <= 2), (c == 3)};
            checks++;
            if ({out, busy, done} !== exp_v) begin
                errors++;
                $display("FAIL zero c=%0d got out/busy/done=%b want %b", c, {out, busy, done}, exp_v);
            end
            next_cycle();
        end
    endtask

    task automatic test_overrun();
        logic [3:0] exp_v;
        clean_start();
        delay = 4'd3;
        width = 8'd2;
        for (int c = 0; c <= 32; c++) begin
            trig    = (c < 2) || (c >= 5 && c < 7);
            ovr_clr = (c == 5) || (c == 30);
            tick    = (c inside {2, 6, 10, 14, 18, 22});
            @(negedge clk);
`ifdef RETRIG_EN
            exp_v = {(c >= 15 && c <= 22), (c >= 1 && c <= 22), (c == 23), 1'b0};
`else
            exp_v = {(c >= 11 && c <= 18), (c >= 1 && c <= 18), (c == 19), (c >= 6 && c <= 30)};
`endif
            checks++;
            if ({out, busy, done, overrun} !== exp_v) begin
                errors++;
                $display("FAIL overrun c=%0d got out/busy/done/ovr=%b want %b", c, {out, busy, done, overrun}, exp_v);
            end
            next_cycle();
        end
        ovr_clr = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_v;
        clean_start();
        delay = 4'd3;
        width = 8'd2;
        for (int c = 0; c <= 28; c++) begin
            trig = (c < 2) || (c == 18) || (c >= 20 && c < 22);
            tick = (c % 4 == 2);
            @(negedge clk);
            exp_v = {(c >= 11 && c <= 18), (c >= 1 && c <= 18) || (c >= 21), (c == 19), (c >= 19)};
            checks++;
            if ({out, busy, done, overrun} !== exp_v) begin
                errors++;
                $display("FAIL back_to_back c=%0d got out/busy/done/ovr=%b want %b", c, {out, busy, done, overrun}, exp_v);
            end
            next_cycle();
        end
    endtask

    task automatic test_reset_mid();
        logic [2:0] exp_v;
        clean_start();
        delay = 4'd3;
        width = 8'd2;
        for (int c = 0; c <= 11; c++) begin
            trig = (c < 3);
            tick = (c inside {2, 6, 10});
            if (c == 11) begin
                @(negedge clk);
                exp_v = 3'b110;
                checks++;
                if ({out, busy, done} !== exp_v) begin
                    errors++;
                    $display("FAIL pre_reset got out/busy/done=%b want %b", {out, busy, done}, exp_v);
                end
            end
            next_cycle();
        end
        rst  = 1'b1;
        trig = 1'b1;
        tick = 1'b0;
        #1;
        exp_v = 3'b000;
        checks++;
        if ({out, busy, done} !== exp_v) begin
            errors++;
            $display("FAIL reset_mid got out/busy/done=%b want %b", {out, busy, done}, exp_v);
        end
        next_cycle();
        next_cycle();
        rst = 1'b0;
        for (int c = 14; c <= 30; c++) begin
            tick = 1'b1;
            @(negedge clk);
            checks++;
            if ({out, busy, done} !== exp_v) begin
                errors++;
                $display("FAIL trig_held c=%0d got out/busy/done=%b want %b", c, {out, busy, done}, exp_v);
            end
            next_cycle();
        end
        trig = 1'b0;
        tick = 1'b0;
    endtask

    task automatic test_max_count();
        logic [2:0] exp_v;
        clean_start();
        delay = 4'd15;
        width = 8'd1;
        for (int c = 0; c <= 19; c++) begin
            trig = (c < 2);
            tick = 1'b1;
            @(negedge clk);
            exp_v = {(c == 16), (c >= 1 && c <= 16), (c == 17)};
            checks++;
            if ({out, busy, done} !== exp_v) begin
                errors++;
                $display("FAIL max_count c=%0d got out/busy/done=%b want %b", c, {out, busy, done}, exp_v);
            end
            next_cycle();
        end
        tick = 1'b0;
    endtask

    initial begin
        rst     = 1'b0;
        tick    = 1'b0;
        trig    = 1'b0;
        delay   = '0;
        width   = '0;
        ovr_clr = 1'b0;
        #1;
        rst = 1'b1;
        test_reset();
        test_basic();
        test_zero();
        test_overrun();
        test_back_to_back();
        test_reset_mid();
        test_max_count();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
